// File: rtl/uart_pkg.sv
// Shared UART receive-path types and default sizing.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_RXBUF_DEPTH = 8;

  typedef struct packed {
    logic                   ferr;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, asynchronous read.
// Zero read latency; no flow control here, the caller owns pointers.
module uart_fifo_mem #(
  parameter int WIDTH  = 9,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_buffer.sv
// Elastic FWFT buffer for received UART frames; entry visible one edge after capture.
// A frame arriving while full (and not popped) is dropped and flagged via sticky overrun.
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = UART_RXBUF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_done,
  input  logic              rx_err,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ferr,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overrun,
  input  logic              ovr_clr
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              push;
  logic              pop;
  logic              wr_en;
  logic              drop;
  logic [DATA_W:0]   mem_wdata;
  logic [DATA_W:0]   mem_rdata;

  assign push  = rx_done | rx_err;
  assign pop   = rd_valid & rd_ready;
  // A pop in the same cycle frees the slot the incoming frame needs.
  assign wr_en = push & (~full | pop);
  assign drop  = push & full & ~pop;

  assign mem_wdata = {rx_err, rx_data};

  uart_fifo_mem #(
    .WIDTH  (DATA_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (mem_wdata),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop) begin
        overrun <= 1'b1;
      end else if (ovr_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  assign empty    = (count == '0);
  assign full     = (count == DEPTH_C);
  assign rd_valid = ~empty;
  // Storage is never cleared, so mask stale contents while empty.
  assign rd_data  = empty ? '0 : mem_rdata[DATA_W-1:0];
  assign rd_ferr  = ~empty & mem_rdata[DATA_W];

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Randomised bench for uart_rx_buffer against a queue-based reference model.
module tb_uart_rx_buffer;
  import uart_pkg::*;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk = 1'b0;
  logic          arst_n;
  logic          rst;
  logic [DW-1:0] rx_data;
  logic          rx_done;
  logic          rx_err;
  logic [DW-1:0] rd_data;
  logic          rd_ferr;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overrun;
  logic          ovr_clr;

  uart_rx_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .rx_err   (rx_err),
    .rd_data  (rd_data),
    .rd_ferr  (rd_ferr),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  always #5 clk = ~clk;

  uart_rx_entry_t mq[$];
  logic [DW-1:0]  popped[$];
  bit             m_ovr;
  int             checks = 0;
  int             errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    uart_rx_entry_t h;
    h = '0;
    if (mq.size() != 0) h = mq[0];
    check("count",    32'(count),    32'(mq.size()));
    check("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
    check("rd_data",  32'(rd_data),  32'(h.data));
    check("rd_ferr",  32'(rd_ferr),  32'(h.ferr));
    check("empty",    32'(empty),    32'(mq.size() == 0));
    check("full",     32'(full),     32'(mq.size() == DEPTH));
    check("overrun",  32'(overrun),  32'(m_ovr));
    check("count_le_depth", 32'(count <= DEPTH), 32'd1);
  endtask

  // Drive one cycle, advance the model by the same edge, then compare.
  task automatic cycle(input logic done, input logic err, input logic [DW-1:0] d,
                       input logic rdy, input logic clr, input logic srst);
    uart_rx_entry_t e;
    bit was_full;
    bit do_pop;
    bit dropped;
    rx_done  = done;
    rx_err   = err;
    rx_data  = d;
    rd_ready = rdy;
    ovr_clr  = clr;
    rst      = srst;
    if (srst) begin
      mq.delete();
      m_ovr = 1'b0;
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() != 0) && rdy;
      dropped  = 1'b0;
      if (do_pop) begin
        e = mq.pop_front();
        popped.push_back(e.data);
      end
      if (done || err) begin
        if (!was_full || do_pop) begin
          e.ferr = err;
          e.data = d;
          mq.push_back(e);
        end else begin
          dropped = 1'b1;
        end
      end
      if (dropped) m_ovr = 1'b1;
      else if (clr) m_ovr = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, 1'b0, '0, rdy, 1'b0, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2 && mq.size() != 0; k++) idle(1'b1);
    check("drain_empty", 32'(empty), 32'd1);
  endtask

  task automatic fill(input logic [DW-1:0] base);
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, base + DW'(i), 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    arst_n = 1'b0; rst = 1'b0; rx_data = '0; rx_done = 1'b0; rx_err = 1'b0;
    rd_ready = 1'b0; ovr_clr = 1'b0; m_ovr = 1'b0;
    #12;
    check_all();
    @(negedge clk);
    arst_n = 1'b1;

    // Single push via rx_done, then pop it.
    cycle(1'b1, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b0);
    check("t1_data", 32'(rd_data), 32'hA5);
    check("t1_count", 32'(count), 32'd1);
    idle(1'b1);

    // Framing-error entry, consumed after one cycle of backpressure.
    cycle(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    check("t2_ferr", 32'(rd_ferr), 32'd1);
    check("t2_data", 32'(rd_data), 32'h3C);
    idle(1'b1);
    check("t2_empty_data", 32'(rd_data), 32'd0);

    // Fill, overflow by one, drain in order.
    popped.delete();
    fill(8'h01);
    check("t3_full", 32'(full), 32'd1);
    cycle(1'b1, 1'b0, 8'h09, 1'b0, 1'b0, 1'b0);
    check("t3_ovr", 32'(overrun), 32'd1);
    check("t3_count", 32'(count), 32'd8);
    drain();
    check("t3_npop", 32'(popped.size()), 32'd8);
    for (int i = 0; i < popped.size(); i++) check("t3_order", 32'(popped[i]), 32'(i + 1));
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);

    // Push into full buffer with simultaneous pop.
    popped.delete();
    fill(8'h10);
    cycle(1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b0);
    check("t4_ovr", 32'(overrun), 32'd0);
    check("t4_count", 32'(count), 32'd8);
    drain();
    check("t4_last", 32'(popped[popped.size()-1]), 32'h55);

    // Random traffic: wrap, backpressure, overflows, clears, sync resets.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom % 3) == 0, ($urandom % 6) == 0, DW'($urandom),
            ($urandom % 100) < ((n / 100) % 2 ? 25 : 70),
            ($urandom % 16) == 0, ($urandom % 120) == 0);
    end
    drain();

    // Drop and clear in the same cycle: set wins; then clear alone.
    fill(8'h40);
    cycle(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'hEF, 1'b0, 1'b1, 1'b0);
    check("t6_set_wins", 32'(overrun), 32'd1);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("t6_clr", 32'(overrun), 32'd0);
    cycle(1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);
    check("t6_count5", 32'(count), 32'd5);
    cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    check("t6_rst_count", 32'(count), 32'd0);
    check("t6_rst_valid", 32'(rd_valid), 32'd0);
    check("t6_rst_ovr", 32'(overrun), 32'd0);

    // Both pulses together push once with ferr set.
    cycle(1'b1, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    check("both_ferr", 32'(rd_ferr), 32'd1);
    check("both_count", 32'(count), 32'd1);

    // Asynchronous reset between edges.
    cycle(1'b1, 1'b0, 8'h78, 1'b0, 1'b0, 1'b0);
    rx_done = 1'b0;
    #2;
    arst_n = 1'b0;
    #1;
    mq.delete();
    m_ovr = 1'b0;
    check_all();
    @(negedge clk);
    arst_n = 1'b1;
    idle(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
